aes_decrypt: RTL and testbench
==============================

AES_DECRYPT -- requirements
Module: aes_decrypt

Interface
REQ-001 Parameter N, default 128: key width in bits; legal values are 128, 192 and 256.
REQ-002 Parameter Nr, default 10: number of rounds; 12 for N=192, 14 for N=256.
REQ-003 Parameter Nk, default 4: key length in 32-bit words; 6 for N=192, 8 for N=256.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 in_valid  input  1  cipher_in/key_in valid.
REQ-007 in_ready  output  1  block idle and able to accept.
REQ-008 cipher_in  input  128  ciphertext block.
REQ-009 key_in  input  N  cipher key.
REQ-010 out_valid  output  1  plain_out holds a result.
REQ-011 out_ready  input  1  consumer accepts result.
REQ-012 plain_out  output  128  recovered plaintext.

Function
REQ-013 Accept occurs on an edge with in_valid=1 and in_ready=1; cipher_in and key_in are registered at that edge.
REQ-014 Byte ordering of cipher_in, key_in and plain_out shall match the AES encrypt block, so encrypt followed by aes_decrypt with the same key returns the original plaintext.
REQ-015 FSM states: IDLE, KEXP, INIT, ROUND, HOLD.
- IDLE: in_ready=1; accept leads to KEXP.
REQ-016 KEXP shall load words w[0..Nk-1] from the key, then compute one word per cycle for K=4(Nr+1)-Nk cycles (40/46/52) into the round-key store; after the last word it moves to INIT.
REQ-017 INIT shall take one cycle: state <= cipher ^ roundkey[Nr]; round counter r <= Nr-1; next state ROUND.
REQ-018 ROUND shall take one cycle per round, Nr cycles in total.
- Each cycle: state <= InvMixColumns(InvSubBytes(InvShiftRows(state)) ^ roundkey[r]).
- InvMixColumns is omitted when r=0.
- r decrements each cycle; leaving r=0 goes to HOLD.
REQ-019 HOLD: out_valid=1 and plain_out=state; a cycle with out_ready=1 returns to IDLE, otherwise plain_out stays stable.
REQ-020 Latency shall be K+1+Nr edges from the accept edge to out_valid high: 51 for 128-bit keys, 59 for 192-bit, 67 for 256-bit.
REQ-021 in_ready shall be 0 in all states except IDLE, so in_valid while busy is ignored and no input is captured.
REQ-022 out_valid and out_ready may both be high in the same cycle: the result is consumed, and in_ready rises on the next edge.
REQ-023 All arithmetic is GF(2^8) with polynomial 0x11B; key expansion follows FIPS-197 (RotWord, SubWord, Rcon; SubWord at i mod Nk = 4 when Nk=8).

Reset
REQ-024 On rst=1 at an edge, the FSM goes to IDLE regardless of state, including mid-KEXP or mid-ROUND, and any in-flight block is discarded.
REQ-025 Reset values: in_ready=1, out_valid=0, plain_out=0, state register=0, r=0.
REQ-026 The round-key store is not reset; the key-valid flag is reset to 0.

Configuration
REQ-027 Macro AES_DEC_KEY_CACHE_EN controls key caching.
- Defined: the last expanded key and a key-valid flag are retained; an accept whose key_in equals the stored key with the flag set goes directly to INIT, skipping KEXP, for latency 1+Nr.
- Undefined: every accept runs KEXP and the cache comparator is absent.
REQ-028 With the macro defined, reset clears the key-valid flag, so the first accept after reset always runs KEXP.

Verification
REQ-029 N=128: key 2b7e151628aed2a6abf7158809cf4f3c, cipher 3925841d02dc09fbdc118597196a0b32 -> plain 3243f6a8885a308d313198a2e0370734 with out_valid at edge 51.
REQ-030 N=192: key 000102...1617, cipher dda97ca4864cdfe06eaf70a0ec0d7191 -> 00112233445566778899aabbccddeeff at edge 59; N=256: key 000102...1e1f, cipher 8ea2b7ca516745bfeafc49904b496089 -> same plaintext at edge 67.
REQ-031 Backpressure: hold out_ready=0 for 20 cycles after out_valid -> plain_out stable and in_ready=0 throughout, then one out_ready pulse -> IDLE.
REQ-032 Busy input: apply in_valid with a different cipher during ROUND -> it is ignored and the first result is unchanged.
REQ-033 Reset mid-operation: assert rst at ROUND r=5 -> next edge in_ready=1 and out_valid=0; a fresh decrypt then gives the correct result.
REQ-034 With AES_DEC_KEY_CACHE_EN defined: two back-to-back 128-bit accepts with the same key -> the second out_valid arrives 11 edges after its accept, and both plaintexts are correct.

Source files
------------

// File: rtl/aes_decrypt.sv
// Iterative AES-128/192/256 decryptor: key expansion at one word per cycle into a round-key store, then one round per cycle.
// Optional key cache enabled by defining AES_DEC_KEY_CACHE_EN.
module aes_decrypt #(
   parameter int N  = 128,
   parameter int Nr = 10,
   parameter int Nk = 4
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [127:0]   cipher_in,
   input  logic [N-1:0]   key_in,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [127:0]   plain_out
);
   localparam int NW = 4 * (Nr + 1);
   localparam int IW = $clog2(NW + 1);
   localparam int RW = $clog2(Nr + 1);
   localparam int KW = $clog2(Nk);

   typedef enum logic [2:0] {IDLE, KEXP, INIT, ROUND, HOLD} state_e;
   state_e st_q, st_d;

   logic [31:0]          w_q [NW];
   logic [127:0]         s_q, s_d;
   logic [IW-1:0]        i_q, i_d;
   logic [2:0]           m_q, m_d;
   logic [7:0]           rc_q, rc_d;
   logic [RW-1:0]        r_q, r_d;
   logic                 accept, hit, kexp_last;
   logic [31:0]          tmp, w_new;
   logic [RW-1:0]        rk_idx;
   logic [IW-1:0]        rb;
   logic [127:0]         rk;
   logic [0:Nk-1][31:0]  kw;

   function automatic logic [7:0] xt(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x;
      p = '0;
      x = a;
      for (int unsigned k = 0; k < 8; k++) begin
         if (b[3'(k)]) p = p ^ x;
         x = xt(x);
      end
      return p;
   endfunction

   // Multiplicative inverse as a^254 (squares a^2..a^128 multiplied together); maps 0 to 0.
   function automatic logic [7:0] ginv(input logic [7:0] a);
      logic [7:0] sq, p;
      sq = a;
      p  = 8'h01;
      for (int unsigned k = 0; k < 7; k++) begin
         sq = gmul(sq, sq);
         p  = gmul(p, sq);
      end
      return p;
   endfunction

   function automatic logic [7:0] sbox(input logic [7:0] a);
      logic [7:0] b;
      b = ginv(a);
      return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [7:0] inv_sbox(input logic [7:0] a);
      return ginv({a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05);
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] x);
      return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
   endfunction

   // Byte 0 is the most significant byte; bytes run column-major (4*col + row).
   function automatic logic [127:0] inv_round(input logic [0:15][7:0] s,
                                              input logic [0:15][7:0] k,
                                              input logic             mix);
      logic [0:15][7:0] t, o;
      for (int unsigned c = 0; c < 4; c++)
         for (int unsigned r = 0; r < 4; r++)
            t[4'(4*c+r)] = inv_sbox(s[4'(4*((c+4-r)%4)+r)]) ^ k[4'(4*c+r)];
      o = t;
      if (mix)
         for (int unsigned c = 0; c < 4; c++)
            for (int unsigned r = 0; r < 4; r++)
               o[4'(4*c+r)] = gmul(t[4'(4*c+r)], 8'h0e)         ^ gmul(t[4'(4*c+(r+1)%4)], 8'h0b) ^
                              gmul(t[4'(4*c+(r+2)%4)], 8'h0d) ^ gmul(t[4'(4*c+(r+3)%4)], 8'h09);
      return o;
   endfunction

   assign kw        = key_in;
   assign accept    = in_valid && in_ready;
   assign kexp_last = (i_q == IW'(NW - 1));

`ifdef AES_DEC_KEY_CACHE_EN
   // Words 0..Nk-1 of the store are the key itself, so they double as the cached key.
   logic                kv_q;
   logic [0:Nk-1][31:0] key_st;
   always_comb begin
      key_st = '0;
      for (int unsigned k = 0; k < Nk; k++) key_st[KW'(k)] = w_q[IW'(k)];
   end
   assign hit = kv_q && (key_st == kw);

   always_ff @(posedge clk) begin
      if (rst)                         kv_q <= 1'b0;
      else if (accept)                 kv_q <= hit;
      else if (st_q == KEXP && kexp_last) kv_q <= 1'b1;
   end
`else
   assign hit = 1'b0;
`endif

   always_comb begin
      tmp = w_q[i_q - IW'(1)];
      if (m_q == '0)                tmp = sub_word({tmp[23:0], tmp[31:24]}) ^ {rc_q, 24'h0};
      else if (Nk > 6 && m_q == 3'd4) tmp = sub_word(tmp);
      w_new = w_q[i_q - IW'(Nk)] ^ tmp;
   end

   assign rk_idx = (st_q == INIT) ? RW'(Nr) : r_q;
   assign rb     = IW'({rk_idx, 2'b00});
   assign rk     = {w_q[rb], w_q[rb + IW'(1)], w_q[rb + IW'(2)], w_q[rb + IW'(3)]};

   always_ff @(posedge clk) begin
      if (accept) begin
         for (int unsigned k = 0; k < Nk; k++) w_q[IW'(k)] <= kw[KW'(k)];
      end else if (st_q == KEXP) begin
         w_q[i_q] <= w_new;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) st_q <= IDLE;
      else     st_q <= st_d;
   end

   always_comb begin
      st_d = st_q;
      case (st_q)
         IDLE:    if (accept) st_d = hit ? INIT : KEXP;
         KEXP:    if (kexp_last) st_d = INIT;
         INIT:    st_d = ROUND;
         ROUND:   if (r_q == '0) st_d = HOLD;
         HOLD:    if (out_ready) st_d = IDLE;
         default: st_d = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (st_q == IDLE);
      out_valid = (st_q == HOLD);
      plain_out = (st_q == HOLD) ? s_q : '0;
   end

   // The state register holds the ciphertext between accept and INIT.
   always_comb begin
      s_d  = s_q;
      i_d  = i_q;
      m_d  = m_q;
      rc_d = rc_q;
      r_d  = r_q;
      case (st_q)
         IDLE: if (accept) begin
            s_d  = cipher_in;
            i_d  = IW'(Nk);
            m_d  = '0;
            rc_d = 8'h01;
         end
         KEXP: begin
            i_d = i_q + IW'(1);
            m_d = (m_q == 3'(Nk - 1)) ? '0 : m_q + 3'd1;
            if (m_q == '0) rc_d = xt(rc_q);
         end
         INIT: begin
            s_d = s_q ^ rk;
            r_d = RW'(Nr - 1);
         end
         ROUND: begin
            s_d = inv_round(s_q, rk, r_q != '0);
            if (r_q != '0) r_d = r_q - RW'(1);
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s_q  <= '0;
         i_q  <= '0;
         m_q  <= '0;
         rc_q <= '0;
         r_q  <= '0;
      end else begin
         s_q  <= s_d;
         i_q  <= i_d;
         m_q  <= m_d;
         rc_q <= rc_d;
         r_q  <= r_d;
      end
   end
endmodule

// File: tb/tb_aes_decrypt.sv
// Self-checking bench for aes_decrypt: FIPS-197 / SP800-38A vectors on 128/192/256-bit instances, scoreboard-based.
module tb_aes_decrypt;
   localparam logic [127:0] K1   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] C1   = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] P1   = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] C1B  = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
   localparam logic [127:0] P1B  = 128'h6bc1bee22e409f96e93d7e117393172a;
   localparam logic [127:0] K2   = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] C2   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] P2   = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] K3   = 128'h0;
   localparam logic [127:0] C3   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
   localparam logic [127:0] P3   = 128'h0;
   localparam logic [191:0] K192 = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
   localparam logic [127:0] C192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
   localparam logic [255:0] K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
   localparam logic [127:0] C256 = 128'h8ea2b7ca516745bfeafc49904b496089;
`ifdef AES_DEC_KEY_CACHE_EN
   localparam int LAT_HIT = 11;
`else
   localparam int LAT_HIT = 51;
`endif

   logic         clk = 1'b0;
   logic         rst, iv128, iv192, iv256, ordy;
   logic [127:0] ct, k128;
   logic [191:0] k192;
   logic [255:0] k256;
   logic         ir128, ir192, ir256, ov128, ov192, ov256;
   logic [127:0] po128, po192, po256;

   logic [127:0] sb_q[$];
   int           n_cmp = 0;
   int           n_bad = 0;

   always #5 clk = ~clk;

   aes_decrypt #(.N(128), .Nr(10), .Nk(4)) u128 (
      .clk(clk), .rst(rst), .in_valid(iv128), .in_ready(ir128), .cipher_in(ct), .key_in(k128),
      .out_valid(ov128), .out_ready(ordy), .plain_out(po128));
   aes_decrypt #(.N(192), .Nr(12), .Nk(6)) u192 (
      .clk(clk), .rst(rst), .in_valid(iv192), .in_ready(ir192), .cipher_in(ct), .key_in(k192),
      .out_valid(ov192), .out_ready(ordy), .plain_out(po192));
   aes_decrypt #(.N(256), .Nr(14), .Nk(8)) u256 (
      .clk(clk), .rst(rst), .in_valid(iv256), .in_ready(ir256), .cipher_in(ct), .key_in(k256),
      .out_valid(ov256), .out_ready(ordy), .plain_out(po256));

   task automatic send128(input logic [127:0] key, input logic [127:0] c, input logic [127:0] p, output bit ok);
      int w = 0;
      @(negedge clk);
      while (!ir128 && w < 200) begin @(negedge clk); w++; end
      ok = ir128;
      k128 = key; ct = c; iv128 = 1'b1;
      sb_q.push_back(p);
      @(posedge clk); #1;
      iv128 = 1'b0;
   endtask

   task automatic wait_out128(output int lat, output bit got);
      got = 1'b0; lat = 0;
      while (!got && lat < 200) begin
         @(posedge clk); lat++; #1;
         if (ov128) got = 1'b1;
      end
   endtask

   task automatic consume();
      @(negedge clk); ordy = 1'b1;
      @(posedge clk); #1; ordy = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; iv128 = 1'b0; iv192 = 1'b0; iv256 = 1'b0; ordy = 1'b0;
      ct = '0; k128 = '0; k192 = K192; k256 = K256;
      repeat (3) @(posedge clk);
      #1;
      n_cmp++; if (ir128 !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b expected 1", ir128); end
      n_cmp++; if (ov128 !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b expected 0", ov128); end
      n_cmp++; if (po128 !== '0) begin n_bad++; $display("FAIL reset_plain_out: got %h expected 0", po128); end
      n_cmp++; if ({ir192, ir256, ov192, ov256} !== 4'b1100) begin
         n_bad++; $display("FAIL reset_192_256: got %b expected 1100", {ir192, ir256, ov192, ov256});
      end
      @(negedge clk); rst = 1'b0;
   endtask

   task automatic test_vectors_128();
      logic [127:0] vk[3], vc[3], vp[3];
      logic [127:0] exp;
      int lat; bit got, ok;
      vk = '{K1, K2, K3}; vc = '{C1, C2, C3}; vp = '{P1, P2, P3};
      for (int unsigned v = 0; v < 3; v++) begin
         send128(vk[v], vc[v], vp[v], ok);
         n_cmp++; if (!ok) begin n_bad++; $display("FAIL vec%0d_accept: in_ready never rose", v); end
         wait_out128(lat, got);
         n_cmp++; if (!got || lat != 51) begin n_bad++; $display("FAIL vec%0d_latency: got %0d expected 51", v, lat); end
         exp = sb_q.pop_front();
         n_cmp++; if (po128 !== exp) begin n_bad++; $display("FAIL vec%0d_plain: got %h expected %h", v, po128, exp); end
         consume();
         n_cmp++; if ({ir128, ov128} !== 2'b10) begin
            n_bad++; $display("FAIL vec%0d_release: got %b expected 10", v, {ir128, ov128});
         end
      end
   endtask

   task automatic test_backpressure();
      logic [127:0] exp;
      int lat, bad_cyc; bit got, ok;
      send128(K2, C2, P2, ok);
      wait_out128(lat, got);
      exp = sb_q.pop_front();
      n_cmp++; if (!got || po128 !== exp) begin n_bad++; $display("FAIL bp_first: got %h expected %h", po128, exp); end
      bad_cyc = 0;
      for (int unsigned c = 0; c < 20; c++) begin
         @(posedge clk); #1;
         n_cmp++;
         if (po128 !== exp || ov128 !== 1'b1 || ir128 !== 1'b0) begin
            n_bad++; bad_cyc++;
            $display("FAIL bp_hold%0d: got plain %h valid %b ready %b expected %h 1 0", c, po128, ov128, ir128, exp);
         end
      end
      consume();
      n_cmp++; if ({ir128, ov128} !== 2'b10) begin n_bad++; $display("FAIL bp_release: got %b expected 10", {ir128, ov128}); end
   endtask

   task automatic test_busy_input();
      logic [127:0] exp;
      int lat; bit got, ok;
      send128(K1, C1, P1, ok);
      repeat (45) @(posedge clk);
      @(negedge clk);
      k128 = K3; ct = C3; iv128 = 1'b1;
      n_cmp++; if (ir128 !== 1'b0) begin n_bad++; $display("FAIL busy_in_ready: got %b expected 0", ir128); end
      repeat (3) @(posedge clk);
      #1; iv128 = 1'b0;
      wait_out128(lat, got);
      n_cmp++; if (!got || lat + 48 != 51) begin n_bad++; $display("FAIL busy_latency: got %0d expected 51", lat + 48); end
      exp = sb_q.pop_front();
      n_cmp++; if (po128 !== exp) begin n_bad++; $display("FAIL busy_plain: got %h expected %h", po128, exp); end
      consume();
      repeat (5) @(posedge clk);
      #1;
      n_cmp++; if ({ir128, ov128} !== 2'b10) begin n_bad++; $display("FAIL busy_no_capture: got %b expected 10", {ir128, ov128}); end
   endtask

   task automatic test_reset_mid();
      logic [127:0] exp, dropped;
      int lat; bit got, ok;
      send128(K1, C1, P1, ok);
      repeat (45) @(posedge clk);
      @(negedge clk); rst = 1'b1;
      @(posedge clk); #1;
      dropped = sb_q.pop_back();
      n_cmp++; if ({ir128, ov128} !== 2'b10) begin n_bad++; $display("FAIL rstmid_flags: got %b expected 10", {ir128, ov128}); end
      n_cmp++; if (po128 !== '0) begin n_bad++; $display("FAIL rstmid_plain: got %h expected 0 (dropped %h)", po128, dropped); end
      @(negedge clk); rst = 1'b0;
      send128(K2, C2, P2, ok);
      wait_out128(lat, got);
      n_cmp++; if (!got || lat != 51) begin n_bad++; $display("FAIL rstmid_latency: got %0d expected 51", lat); end
      exp = sb_q.pop_front();
      n_cmp++; if (po128 !== exp) begin n_bad++; $display("FAIL rstmid_plain2: got %h expected %h", po128, exp); end
      consume();
   endtask

   task automatic test_back_to_back();
      logic [127:0] exp;
      int lat; bit got, ok;
      send128(K1, C1, P1, ok);
      wait_out128(lat, got);
      n_cmp++; if (!got || lat != 51) begin n_bad++; $display("FAIL b2b_lat1: got %0d expected 51", lat); end
      exp = sb_q.pop_front();
      n_cmp++; if (po128 !== exp) begin n_bad++; $display("FAIL b2b_plain1: got %h expected %h", po128, exp); end
      consume();
      send128(K1, C1B, P1B, ok);
      wait_out128(lat, got);
      n_cmp++; if (!got || lat != LAT_HIT) begin n_bad++; $display("FAIL b2b_lat2: got %0d expected %0d", lat, LAT_HIT); end
      exp = sb_q.pop_front();
      n_cmp++; if (po128 !== exp) begin n_bad++; $display("FAIL b2b_plain2: got %h expected %h", po128, exp); end
      consume();
   endtask

   task automatic test_key_sizes();
      logic [127:0] exp, obs;
      int lat, want; bit got;
      for (int unsigned sel = 0; sel < 2; sel++) begin
         want = (sel == 0) ? 59 : 67;
         @(negedge clk);
         ct = (sel == 0) ? C192 : C256;
         if (sel == 0) iv192 = 1'b1; else iv256 = 1'b1;
         sb_q.push_back(P2);
         @(posedge clk); #1;
         iv192 = 1'b0; iv256 = 1'b0;
         lat = 0; got = 1'b0;
         while (!got && lat < 200) begin
            @(posedge clk); lat++; #1;
            got = (sel == 0) ? ov192 : ov256;
         end
         n_cmp++; if (!got || lat != want) begin n_bad++; $display("FAIL size%0d_latency: got %0d expected %0d", sel, lat, want); end
         obs = (sel == 0) ? po192 : po256;
         exp = sb_q.pop_front();
         n_cmp++; if (obs !== exp) begin n_bad++; $display("FAIL size%0d_plain: got %h expected %h", sel, obs, exp); end
         consume();
         n_cmp++; if (((sel == 0) ? ir192 : ir256) !== 1'b1) begin
            n_bad++; $display("FAIL size%0d_release: got 0 expected 1", sel);
         end
      end
   endtask

   initial begin
      test_reset();
      test_vectors_128();
      test_backpressure();
      test_busy_input();
      test_reset_mid();
      test_back_to_back();
      test_key_sizes();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached, got no completion expected finish");
      $fatal(1);
   end
endmodule
